// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Holds the frame state encoding, the oversample ratio and the parity helper.
// No logic of its own; purely declarations.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int MAX_DATABITS = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity over a word zero-extended to the widest legal frame.
    function automatic logic even_parity(input logic [MAX_DATABITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake between a producer and the UART transmitter.
// A transfer happens on any clk edge where tx_valid && tx_ready.
// Master drives data/valid, slave (the transmitter) drives ready.
interface uart_tx_if #(
    parameter int DATABITS = 8
);
    logic [DATABITS-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop framer.
// Latency: start bit begins on the first baud16 tick after the word is buffered; 16 ticks per bit.
// Backpressure: tx_ready low while the holding register is full; it frees when a frame loads.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATABITS  = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud16,
    uart_tx_if.slave   tx,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] BIT_LAST  = 4'(DATABITS - 1);

    uart_state_e         state_q, state_d;
    logic [3:0]          tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic [DATABITS-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic [DATABITS-1:0] hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                line_q, line_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load;

    // Ready depends only on the holding flag so a producer never sees a combinational path from baud16.
    assign tx.tx_ready = !hold_full_q;
    assign tx_line     = line_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;

    // Next-state: handshake capture, bit timing and frame sequencing.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        line_d      = line_q;
        done_d      = 1'b0;
        load        = 1'b0;

        // Accept only into an empty holding register; a load needs it full, so the two never coincide.
        if (tx.tx_valid && !hold_full_q) begin
            hold_d      = tx.tx_data;
            hold_full_d = 1'b1;
        end

        if (baud16) begin
            if (state_q == IDLE) begin
                load = hold_full_q;
            end else begin
                tick_d = tick_q + 4'd1;
                if (tick_q == TICK_LAST) begin
                    case (state_q)
                        START: begin
                            line_d  = shift_q[0];
                            bit_d   = 4'd0;
                            state_d = DATA;
                        end
                        DATA: begin
                            if (bit_q < BIT_LAST) begin
                                shift_d = shift_q >> 1;
                                line_d  = shift_q[1];
                                bit_d   = bit_q + 4'd1;
                            end else if (PARITY_EN) begin
                                line_d  = par_q;
                                state_d = PARITY;
                            end else begin
                                line_d  = 1'b1;
                                state_d = STOP;
                            end
                        end
                        PARITY: begin
                            line_d  = 1'b1;
                            state_d = STOP;
                        end
                        STOP: begin
                            done_d = 1'b1;
                            if (hold_full_q) begin
                                load = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                        default: begin
                            line_d  = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
            end
        end

        // Frame load: parity is fixed from the captured word so later shifts do not disturb it.
        if (load) begin
            shift_d     = hold_q;
            par_d       = even_parity(MAX_DATABITS'(hold_q));
            hold_full_d = 1'b0;
            line_d      = 1'b0;
            tick_d      = 4'd0;
            state_d     = START;
        end

        busy_d = (state_d != IDLE);
    end

    // State registers; reset forces the line idle-high immediately and drops any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_q      <= 4'd0;
            bit_q       <= 4'd0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            line_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default 8-bit/parity instance and a 7-bit/no-parity instance side by side.
// baud16 pulses every 4 clks, so each bit spans 64 clks.
module tb_uart_tx;

    logic clk;
    logic reset;
    logic baud16;
    int   cyc;
    int   bcnt;

    uart_tx_if #(.DATABITS(8)) ifa();
    uart_tx_if #(.DATABITS(7)) ifb();

    logic line_a, busy_a, done_a;
    logic line_b, busy_b, done_b;

    uart_tx #(.DATABITS(8), .PARITY_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .baud16(baud16), .tx(ifa),
        .tx_line(line_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx #(.DATABITS(7), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .baud16(baud16), .tx(ifb),
        .tx_line(line_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    int n_vec = 0;
    int n_bad = 0;
    int ndone_a = 0, ndone_b = 0;
    int exp_done_a = 0, exp_done_b = 0;

    typedef struct {
        bit          sel;
        logic [8:0]  data;
        logic [15:0] frame;
        int          nbits;
    } vec_t;

    vec_t vt[6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud16 = 1'b0;
        bcnt   = 0;
        forever begin
            @(negedge clk);
            bcnt   = (bcnt + 1) % 4;
            baud16 = (bcnt == 0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a) ndone_a <= ndone_a + 1;
        if (done_b) ndone_b <= ndone_b + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic get_line(input bit sel);
        return sel ? line_b : line_a;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction
    function automatic logic get_ready(input bit sel);
        return sel ? ifb.tx_ready : ifa.tx_ready;
    endfunction

    // Frame image for an 8-bit word with even parity: bit i is the line level in slot i.
    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {5'b0, 1'b1, ^d, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the handshake.
    task automatic offer(input bit sel, input logic [8:0] data, output int waited);
        waited = 0;
        if (sel) begin
            ifb.tx_data = data[6:0]; ifb.tx_valid = 1'b1;
        end else begin
            ifa.tx_data = data[7:0]; ifa.tx_valid = 1'b1;
        end
        while (!get_ready(sel) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!get_ready(sel)) check("offer ready timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ifa.tx_valid = 1'b0;
        ifb.tx_valid = 1'b0;
        @(negedge clk);
    endtask

    // Waits for the start edge, then checks the first and last clk of every bit slot,
    // no early tx_done, tx_done high right after the stop bit, and tx_busy afterwards.
    task automatic capture(input bit sel, input logic [15:0] frame, input int nbits,
                           input bit more, input string tag, output int t_start);
        int   waited;
        logic s0;
        bit   early;
        waited  = 0;
        early   = 1'b0;
        t_start = cyc;
        while (get_line(sel) !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (get_line(sel) !== 1'b0) begin
            check($sformatf("%s start timeout", tag), 32'(get_line(sel)), 32'd0);
            return;
        end
        t_start = cyc;
        check($sformatf("%s busy_rise", tag), 32'(get_busy(sel)), 32'd1);
        for (int b = 0; b < nbits; b++) begin
            s0 = get_line(sel);
            for (int j = 0; j < 63; j++) begin
                @(negedge clk);
                early |= get_done(sel);
            end
            check($sformatf("%s bit%0d", tag, b), {30'd0, s0, get_line(sel)},
                  {30'd0, frame[b], frame[b]});
            @(negedge clk);
            if (b < nbits - 1) early |= get_done(sel);
        end
        check($sformatf("%s early_done", tag), 32'(early), 32'd0);
        check($sformatf("%s done", tag), 32'(get_done(sel)), 32'd1);
        check($sformatf("%s busy_after", tag), 32'(get_busy(sel)), 32'(more));
    endtask

    task automatic rx_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            while (!baud16) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Independent 16x-oversampling receiver on dut_a's line: mid-bit sampling from the start edge.
    task automatic rx_frame(output logic [7:0] w, output bit perr, output bit ferr);
        int   g;
        logic p;
        g    = 0;
        w    = 8'h00;
        perr = 1'b1;
        ferr = 1'b1;
        while (g < 2000) begin
            @(posedge clk); #1;
            if (baud16 && !line_a) break;
            g++;
        end
        if (g >= 2000) return;
        rx_ticks(8);
        if (line_a) return;
        for (int i = 0; i < 8; i++) begin
            rx_ticks(16);
            w[i] = line_a;
        end
        rx_ticks(16);
        p    = line_a;
        perr = p ^ (^w);
        rx_ticks(16);
        ferr = !line_a;
    endtask

    int          w, w2, s1, s2, g, d_before;
    logic [7:0]  acc, rxw;
    bit          perr, ferr;

    initial begin
        vt[0] = '{1'b0, 9'h0A5, 16'h054A, 11};
        vt[1] = '{1'b0, 9'h0FF, 16'h05FE, 11};
        vt[2] = '{1'b0, 9'h000, 16'h0400, 11};
        vt[3] = '{1'b0, 9'h03C, 16'h0478, 11};
        vt[4] = '{1'b1, 9'h055, 16'h01AA,  9};
        vt[5] = '{1'b1, 9'h00F, 16'h011E,  9};

        ifa.tx_data = '0; ifa.tx_valid = 1'b0;
        ifb.tx_data = '0; ifb.tx_valid = 1'b0;
        acc = 8'h00;

        reset = 1'b1;
        #2;
        check("rst line_a",  32'(line_a),       32'd1);
        check("rst ready_a", 32'(ifa.tx_ready), 32'd1);
        check("rst busy_a",  32'(busy_a),       32'd0);
        check("rst done_a",  32'(done_a),       32'd0);
        check("rst line_b",  32'(line_b),       32'd1);
        check("rst ready_b", 32'(ifb.tx_ready), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle line_a", 32'(line_a), 32'd1);

        // Single frames from the table.
        for (int i = 0; i < 6; i++) begin
            offer(vt[i].sel, vt[i].data, w);
            capture(vt[i].sel, vt[i].frame, vt[i].nbits, 1'b0, $sformatf("vec%0d", i), s1);
            if (vt[i].sel) exp_done_b++; else exp_done_a++;
            repeat (10) @(negedge clk);
        end

        // Back-to-back: second word buffered during the first frame's data bits.
        offer(1'b0, 9'h001, w);
        fork
            capture(1'b0, 16'h0602, 11, 1'b1, "b2b0", s1);
            begin
                repeat (300) @(negedge clk);
                offer(1'b0, 9'h080, w2);
            end
        join
        check("b2b accept wait", 32'(w2), 32'd0);
        capture(1'b0, 16'h0700, 11, 1'b0, "b2b1", s2);
        check("b2b start spacing", 32'(s2 - s1), 32'd704);
        exp_done_a += 2;
        repeat (10) @(negedge clk);

        // Valid held high with changing data while the holding register is full.
        offer(1'b0, 9'h011, w);
        fork
            capture(1'b0, frame8(8'h11), 11, 1'b1, "chg0", s1);
            begin
                g = 0;
                ifa.tx_valid = 1'b1;
                while (g < 1000) begin
                    ifa.tx_data = 8'($urandom);
                    if (ifa.tx_ready) begin
                        acc = ifa.tx_data;
                        break;
                    end
                    @(negedge clk);
                    g++;
                end
                @(posedge clk); #1;
                ifa.tx_valid = 1'b0;
                check("chg accept bound", 32'(g < 1000), 32'd1);
            end
        join
        capture(1'b0, frame8(acc), 11, 1'b0, "chg1", s2);
        exp_done_a += 2;
        repeat (200) begin
            @(negedge clk);
            if (line_a !== 1'b1 || busy_a !== 1'b0) g = -1;
        end
        check("chg no extra frame", 32'(g == -1), 32'd0);

        // Reset during data bit 3 with a word pending.
        offer(1'b0, 9'h0A5, w);
        g = 0;
        while (line_a !== 1'b0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        repeat (4 * 64 + 30) @(negedge clk);
        offer(1'b0, 9'h077, w);
        check("pre-rst line_a",  32'(line_a),       32'd0);
        check("pre-rst ready_a", 32'(ifa.tx_ready), 32'd0);
        d_before = ndone_a;
        #3;
        reset = 1'b1;
        #1;
        check("async rst line_a",  32'(line_a),       32'd1);
        check("async rst ready_a", 32'(ifa.tx_ready), 32'd1);
        check("async rst busy_a",  32'(busy_a),       32'd0);
        @(negedge clk);
        reset = 1'b0;
        g = 0;
        repeat (100) begin
            @(negedge clk);
            if (line_a !== 1'b1) g = 1;
        end
        check("post-rst idle line", 32'(g), 32'd0);
        check("post-rst no done", 32'(ndone_a - d_before), 32'd0);

        // Clean frame after reset, decoded by a 16x receiver.
        offer(1'b0, 9'h03C, w);
        fork
            capture(1'b0, 16'h0478, 11, 1'b0, "loop", s1);
            rx_frame(rxw, perr, ferr);
        join
        exp_done_a++;
        check("rx word",         32'(rxw),  32'h3C);
        check("rx parity_error", 32'(perr), 32'd0);
        check("rx framing",      32'(ferr), 32'd0);

        repeat (5) @(negedge clk);
        check("done count a", 32'(ndone_a), 32'(exp_done_a));
        check("done count b", 32'(ndone_b), 32'(exp_done_b));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Parallel-to-serial UART transmitter driving the serial line that the UART receiver samples. Accepts words on a valid/ready handshake into a one-entry holding register and emits frames: start bit, DATABITS data bits LSB first, an optional even-parity bit, and one stop bit. Each bit lasts exactly 16 `baud16` ticks, using the same 16x oversample enable the receiver uses. A frame from this block must be decoded by the receiver without any change to the receiver.

## Interface
- DATABITS, 8: data bits per frame. Legal range 5..9.
- PARITY_EN, 1: 1 inserts an even-parity bit (XOR of the data bits) after the data; 0 omits it.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- baud16  in  1  single-cycle enable at 16x baud rate; the FSM advances only on cycles where it is high
- tx_data  in  DATABITS  word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty; a transfer occurs on a clk edge with tx_valid && tx_ready
- tx_line  out  1  serial output, idle high, registered
- tx_busy  out  1  high while a frame is in progress (state != IDLE)
- tx_done  out  1  one-clk pulse when the stop bit completes

## Operation
- Reset values: tx_line=1, tx_ready=1, tx_busy=0, tx_done=0. Reset also clears the FSM, counters, shift register and holding register.
- Handshake:
  - Transfers are evaluated on every clk edge and are not gated by baud16.
  - tx_ready = !hold_full.
  - A transfer loads hold_reg and sets hold_full.
  - tx_data is ignored while tx_ready is low.
- States:
  - IDLE, START, DATA, PARITY, STOP.
  - The 4-bit tick_cnt and the bit_cnt advance only on baud16.
  - A bit ends on the baud16 tick where tick_cnt==15; tick_cnt then wraps to 0.
- IDLE:
  - On a baud16 tick with hold_full: shift_reg<=hold_reg, hold_full<=0, tx_line<=0, tick_cnt<=0, go to START.
  - With hold_full low, tx_line stays 1.
- START end: tx_line<=shift_reg[0], bit_cnt<=0, go to DATA.
- DATA end:
  - If bit_cnt < DATABITS-1: shift right, drive the next bit, bit_cnt++.
  - Else, PARITY_EN=1: drive the parity bit (computed from the word captured at load) and go to PARITY.
  - Else, PARITY_EN=0: drive tx_line=1 and go to STOP.
- PARITY end: tx_line<=1, go to STOP.
- STOP end:
  - tx_done<=1 for one clk.
  - If hold_full: start the next frame on that same tick (same actions as the IDLE load). Back-to-back frames have no idle gap.
  - Else go to IDLE.
- Frame length: (2+DATABITS+PARITY_EN)*16 baud16 ticks. For defaults this is 176 ticks.
- Simultaneous events: a handshake and a hold-register load in the same clk cannot collide, because a load requires hold_full=1 and that forces tx_ready=0. A handshake in the clk edge after the load is accepted.
- Reset mid-frame: tx_line returns to 1 immediately (asynchronous) and the partial frame is abandoned. No tx_done is generated.
- baud16 held high continuously is legal: one tick per clk.

## Timing
- tx_line, tx_busy and tx_done are registered. tx_ready is derived combinationally from the hold_full register only.
- Start-bit falling edge: the first baud16 tick after the handshake. This is at least 1 clk after the handshake, and at most 1 baud16 period plus 1 clk after it while IDLE.
- tx_ready rises 1 clk after the tick that loads the frame. The next word can therefore be buffered a full frame early.
- tx_busy rises with the start-bit edge and falls on the clk after the stop-bit end when no word is pending.
- tx_done is asserted in the clk after the final stop tick and lasts exactly 1 clk.

## Structure
- Shared package uart_pkg, also used by the receiver:
  - state encodings IDLE/START/DATA/PARITY/STOP (3-bit);
  - OVERSAMPLE=16;
  - an even-parity function.
- No sub-module. The holding register, shift register and FSM stay in one module. baud16 comes from the existing shared baud generator.

## Test plan
- Single word, defaults, baud16 every 4 clks, tx_data=8'hA5:
  - tx_line = 0, then 1,0,1,0,0,1,0,1 (LSB first), then parity 0, then 1;
  - each level held for 64 clks;
  - exactly one tx_done.
- Back-to-back words 8'h01 then 8'h80, second offered while the first is in DATA:
  - second accepted immediately;
  - second start bit begins on the tick after the first stop ends;
  - parity bits 1 and 1;
  - two tx_done pulses 176 ticks apart.
- PARITY_EN=0, DATABITS=7, tx_data=7'h55: frame length 144 ticks, no parity slot.
- tx_valid held high while tx_ready=0 with changing tx_data: only the word present at the accepted edge is transmitted.
- Reset asserted during bit 3: tx_line=1 and tx_ready=1 asynchronously. After release the next word sends a clean full frame with no stale bits.
- Loopback into the UART receiver with the same baud16, word 8'h3C: the receiver's rx_done fires with parity_error=0 and the expected word.
